// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the alu_seq registered ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_AND = 4'b0010,
        OP_ORR = 4'b0011,
        OP_NZB = 4'b0100,
        OP_LSL = 4'b0101,
        OP_LSR = 4'b0110,
        OP_ASR = 4'b0111,
        OP_EOR = 4'b1000,
        OP_MUL = 4'b1001
    } alu_op_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_t;

    function automatic int shamt_width(input int width);
        return $clog2(width);
    endfunction

    // Signed overflow from operand and result sign bits.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);
    localparam int CW = $clog2(WIDTH);

    logic             run_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] addend_s;

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        addend_s = {WIDTH{1'b0}};
        if (mplier_q[0]) begin
            addend_s = mcand_q;
        end else begin
            addend_s = {WIDTH{1'b0}};
        end
        acc_d = acc_q + addend_s;
    end

    // The final product leaves combinationally so the parent loads it on the count-0 edge.
    assign done_o    = run_q && (cnt_q == {CW{1'b0}});
    assign product_o = acc_d;

    // Iteration state: load on start, then shift one bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= CW'(WIDTH - 1);
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= {WIDTH{1'b0}};
        end else if (run_q) begin
            run_q    <= (cnt_q != {CW{1'b0}});
            cnt_q    <= cnt_q - CW'(1);
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            acc_q    <= acc_d;
        end else begin
            run_q    <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and NZCV-style flags.
// Define ALU_SEQ_MUL_EN to build the iterative multi-cycle MUL path.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int SHAMT_LSB = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err,
    output logic             busy
);
    localparam int SHW = shamt_width(WIDTH);

    alu_state_t       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] res_s;
    logic             carry_s, ovf_s, err_s, is_mul_s;
    logic             accept_s, in_ready_s, busy_s, mul_done_s;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mul_prod_s;
`endif

    assign add_s    = {1'b0, a} + {1'b0, b};
    assign sub_s    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt_s  = b[SHAMT_LSB +: SHW];
    assign accept_s = in_valid && in_ready_s;

    // Single-cycle operation results and arithmetic flags.
    always_comb begin
        res_s    = {WIDTH{1'b0}};
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        err_s    = 1'b0;
        is_mul_s = 1'b0;
        case (alu_op)
            OP_ADD: begin
                res_s   = add_s[WIDTH-1:0];
                carry_s = add_s[WIDTH];
                ovf_s   = add_ovf(a[WIDTH-1], b[WIDTH-1], add_s[WIDTH-1]);
            end
            OP_SUB: begin
                res_s   = sub_s[WIDTH-1:0];
                carry_s = sub_s[WIDTH];
                ovf_s   = sub_ovf(a[WIDTH-1], b[WIDTH-1], sub_s[WIDTH-1]);
            end
            OP_AND: res_s = a & b;
            OP_ORR: res_s = a | b;
            OP_EOR: res_s = a ^ b;
            OP_NZB: res_s = {{(WIDTH-1){1'b0}}, |b};
            OP_LSL: res_s = a << shamt_s;
            OP_LSR: res_s = a >> shamt_s;
            OP_ASR: res_s = $signed(a) >>> shamt_s;
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: is_mul_s = 1'b1;
`endif
            default: err_s = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (accept_s && is_mul_s),
        .a_i       (a),
        .b_i       (b),
        .done_o    (mul_done_s),
        .product_o (mul_prod_s)
    );
`else
    assign mul_done_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_d = MUL_BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_BUSY: begin
                if (mul_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = MUL_BUSY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: issue stalls while busy or while an unretired result is held.
    always_comb begin
        in_ready_s = (state_q == IDLE) && (!out_valid_q || out_ready);
`ifdef ALU_SEQ_MUL_EN
        busy_s     = (state_q == MUL_BUSY);
`else
        busy_s     = 1'b0;
`endif
    end

    // Result/flag next-state: load on single-cycle accept or multiplier completion.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        if (accept_s && !is_mul_s) begin
            out_valid_d = 1'b1;
            result_d    = res_s;
            zero_d      = (res_s == {WIDTH{1'b0}});
            neg_d       = res_s[WIDTH-1];
            carry_d     = carry_s;
            ovf_d       = ovf_s;
            err_d       = err_s;
`ifdef ALU_SEQ_MUL_EN
        end else if (mul_done_s) begin
            out_valid_d = 1'b1;
            result_d    = mul_prod_s;
            zero_d      = (mul_prod_s == {WIDTH{1'b0}});
            neg_d       = mul_prod_s[WIDTH-1];
            carry_d     = 1'b0;
            ovf_d       = 1'b0;
            err_d       = 1'b0;
`endif
        end else begin
            result_d    = result_q;
        end
    end

    // Result and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops against a behavioural model.
module tb_alu_seq;
    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero, neg, carry, ovf, err, busy;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [63:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
        logic        e;
        logic        mul;
    } exp_t;

    exp_t last_exp;

    alu_seq #(.WIDTH(W), .SHAMT_LSB(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model written from the operation table with plain arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        int unsigned sh;
        logic signed [63:0] sx, sy, sr;
        e  = '0;
        sh = int'((y >> 10) % 64);
        sx = x;
        sy = y;
        case (op)
            4'd0: begin
                e.res = x + y;
                e.c   = (e.res < x);
                sr    = e.res;
                e.v   = ((sx < 0) == (sy < 0)) && ((sr < 0) != (sx < 0));
            end
            4'd1: begin
                e.res = x - y;
                e.c   = (x >= y);
                sr    = e.res;
                e.v   = ((sx < 0) != (sy < 0)) && ((sr < 0) != (sx < 0));
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd8: e.res = x ^ y;
            4'd4: e.res = (y != 64'd0) ? 64'd1 : 64'd0;
            4'd5: e.res = x << sh;
            4'd6: e.res = x >> sh;
            4'd7: e.res = sx >>> sh;
`ifdef ALU_SEQ_MUL_EN
            4'd9: begin
                e.res = x * y;
                e.mul = 1'b1;
            end
`endif
            default: e.e = 1'b1;
        endcase
        e.z = (e.res == 64'd0);
        e.n = e.res[63];
        return e;
    endfunction

    // Issue one op at a negedge, wait for its result and compare against the model.
    task automatic run_op(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv, input string tag);
        exp_t e;
        int cyc;
        e = model(op, av, bv);
        last_exp = e;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        alu_op    = op;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        a        = ~av;
        b        = ~bv;
        cyc      = 0;
        if (e.mul) begin
            while (out_valid !== 1'b1 && cyc < 200) begin
                check({tag, ".busy"}, 64'(busy), 64'd1);
                check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
                cyc++;
                @(negedge clk);
            end
            check({tag, ".mul_latency"}, 64'(cyc), 64'(W));
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".result"}, result, e.res);
        check({tag, ".flags"}, 64'({zero, neg, carry, ovf, err}), 64'({e.z, e.n, e.c, e.v, e.e}));
    endtask

    // Hold out_ready low with a competing offer; the held result must not change.
    task automatic stall(input int n, input string tag);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 4'd2;
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".hold_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".hold_result"}, result, last_exp.res);
            check({tag, ".hold_flags"}, 64'({zero, neg, carry, ovf, err}),
                  64'({last_exp.z, last_exp.n, last_exp.c, last_exp.v, last_exp.e}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, ".retired"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] av, bv;
        int          seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 4'd0;
        a         = 64'd0;
        b         = 64'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.result", result, 64'd0);
        check("rst.flags", 64'({zero, neg, carry, ovf, err}), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);

        run_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, "add_ovf");
        check("add_ovf.lit", result, 64'h8000_0000_0000_0000);
        run_op(4'd1, 64'd5, 64'd5, "sub_eq");
        check("sub_eq.zc", 64'({zero, carry}), 64'b11);
        run_op(4'd1, 64'd3, 64'd5, "sub_neg");
        check("sub_neg.lit", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(4'd6, 64'hF000_0000_0000_0000, 64'h1000, "lsr");
        check("lsr.lit", result, 64'h0F00_0000_0000_0000);
        run_op(4'd7, 64'hF000_0000_0000_0000, 64'h1000, "asr");
        check("asr.lit", result, 64'hFF00_0000_0000_0000);
        run_op(4'd5, 64'hF000_0000_0000_0000, 64'h1000, "lsl");
        check("lsl.lit", result, 64'd0);
        run_op(4'd4, 64'd9, 64'd0, "nzb0");
        run_op(4'd4, 64'd9, 64'h100, "nzb1");

        run_op(4'd3, 64'h00F0, 64'h0F0F, "orr");
        stall(3, "bp");
        run_op(4'd8, 64'hAAAA, 64'h5555, "b2b0");
        run_op(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "b2b1");
        run_op(4'd2, 64'hFF00, 64'h0FF0, "b2b2");
        run_op(4'd1, 64'd0, 64'd1, "b2b3");

        run_op(4'd15, 64'd12, 64'd34, "illegal");
        check("illegal.err", 64'({err, zero}), 64'b11);
        run_op(4'd2, 64'd6, 64'd3, "after_illegal");
        check("after_illegal.err", 64'(err), 64'd0);

        run_op(4'd9, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, "mul");
`ifdef ALU_SEQ_MUL_EN
        check("mul.lit", result, 64'hFFFF_FFFF_FFFF_FFEB);
        in_valid  = 1'b1;
        alu_op    = 4'd9;
        a         = 64'd123;
        b         = 64'd456;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("mul_rst.busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mul_rst.out_valid", 64'(out_valid), 64'd0);
        check("mul_rst.busy", 64'(busy), 64'd0);
        check("mul_rst.result", result, 64'd0);
        check("mul_rst.in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check("mul_rst.no_result", 64'(seen), 64'd0);
`else
        check("mul_off.err", 64'(err), 64'd1);
`endif

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            run_op(op, av, bv, "rand");
            if ($urandom_range(0, 3) == 0) stall(2, "rand_bp");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the datapath ALU. Accepts one operation per valid/ready handshake, returns a registered result with NZCV-style flags, and adds an optional iterative multiplier for multi-cycle `MUL`. It sits between the register-read stage and the writeback mux, and stalls issue through `in_ready` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, default 64: operand and result width; must be ≥8 and a power of two.
- `SHAMT_LSB`, default 10: LSB of the shift-amount field inside `b`. The field is `b[SHAMT_LSB +: $clog2(WIDTH)]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  block can accept an operation this cycle.
- `alu_op`  in  4  opcode (see Operation).
- `a`  in  WIDTH  operand A, signed.
- `b`  in  WIDTH  operand B, signed.
- `out_valid`  out  1  result and flags are valid.
- `out_ready`  in  1  consumer takes the result this cycle.
- `result`  out  WIDTH  registered result.
- `zero`, `neg`, `carry`, `ovf`  out  1 each  registered flags.
- `err`  out  1  the accepted opcode was illegal or not compiled in.
- `busy`  out  1  a multi-cycle operation is in progress.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB (a−b), 0010 AND, 0011 ORR, 1000 EOR.
  - 0100 NZB: result = 1 if b≠0, else 0.
  - 0101 LSL: a << shamt.
  - 0110 LSR: logical right shift, zero fill.
  - 0111 ASR: arithmetic right shift, sign fill.
  - 1001 MUL: low WIDTH bits of a×b.
  - All other codes are illegal.
- Accept: an operation is accepted when `in_valid && in_ready`. Operands and opcode are captured only on acceptance.
- `in_ready = (state==IDLE) && (!out_valid || out_ready)`. Throughput is one single-cycle op per clock under continuous `out_ready`.
- FSM states:
  - IDLE: a single-cycle op on accept loads `result`/flags and sets `out_valid`; state stays IDLE. MUL on accept goes to MUL_BUSY.
  - MUL_BUSY: radix-2 shift-add, one bit of `b` per cycle, counter from WIDTH−1 down to 0. At count 0 the product is loaded, `out_valid` is set, and the FSM returns to IDLE.
- `out_valid` holds, and `result`/flags stay stable, until `out_ready` is seen. A new result may be loaded in the same cycle `out_ready` retires the old one.
- Flags:
  - `zero` = (result==0) and `neg` = result[WIDTH−1] for every op.
  - `carry` = carry-out of ADD. For SUB, `carry` = no-borrow (a ≥ b unsigned).
  - `ovf` = signed overflow for ADD/SUB.
  - `carry` = `ovf` = 0 for all other ops.
- Illegal opcode: result 0, `zero`=1, other flags 0, `err`=1, latency as a single-cycle op. `err` is 0 for every legal op.
- Arithmetic is modulo 2^WIDTH. A shift amount ≥ WIDTH cannot occur because the field is exactly $clog2(WIDTH) bits.

## Timing
- Reset values: `out_valid`=0, `result`=0, `zero`=0, `neg`=0, `carry`=0, `ovf`=0, `err`=0, `busy`=0, state IDLE, `in_ready`=1 in the first cycle after reset deasserts.
- Single-cycle op: accepted in cycle N, so `out_valid`=1 in cycle N+1.
- MUL: accepted in cycle N, so `busy`=1 in cycles N+1 … N+WIDTH and `out_valid`=1 in cycle N+WIDTH+1. `in_ready`=0 throughout.
- Backpressure: if `out_ready`=0 while `out_valid`=1, then `in_ready`=0 and nothing is overwritten.
- Reset asserted mid-MUL aborts the operation: no result is emitted and all outputs return to reset values on the next edge.
- `in_valid` while `in_ready`=0 is ignored. There is no requirement to hold `in_valid`.

## Configuration
- `ALU_SEQ_MUL_EN` defined: the MUL opcode (1001) and the MUL_BUSY path are built.
- Not defined: 1001 is treated as illegal (`err`=1, result 0, 1-cycle latency). `busy` is tied to 0 and no multiplier logic is present.

## Structure
- Package `alu_seq_pkg` holds:
  - `alu_op_t` enum with the opcode constants above;
  - `alu_state_t` (IDLE, MUL_BUSY);
  - a function returning the shift-amount width from `WIDTH`.
- One sub-module, `alu_mul_iter`: a shift-add datapath with start/done, product register and counter. It is instantiated only under `ALU_SEQ_MUL_EN`.
- Single-cycle combinational ops and flag generation stay in `alu_seq`.

## Test plan
- ADD, WIDTH=64: a=0x7FFF_FFFF_FFFF_FFFF, b=1 → result 0x8000_0000_0000_0000, `neg`=1, `ovf`=1, `carry`=0, `out_valid` one cycle after accept.
- SUB: a=5, b=5 → result 0, `zero`=1, `carry`=1. Next, a=3, b=5 → result −2, `neg`=1, `carry`=0.
- Shifts with b[15:10]=4 and a=0xF000_0000_0000_0000: LSR → 0x0F00_0000_0000_0000; ASR → 0xFF00_0000_0000_0000; LSL → 0.
- MUL (macro on): a=−3, b=7 → result −21 after exactly WIDTH+1 cycles. `busy` is high for WIDTH cycles and `in_ready`=0 throughout. A reset pulse mid-MUL yields no `out_valid`. With the macro off, the same op gives `err`=1 and result 0 after 1 cycle.
- Backpressure: hold `out_ready`=0 for 3 cycles after an ORR → `result` stable, `in_ready`=0. Then issue back-to-back ops with `out_ready`=1 → one result per cycle.
- Opcode 1111 → `err`=1, `zero`=1, result 0. The following legal op clears `err`.
